bsg_fifo_1r1w_tracked: RTL and testbench



---
 rtl/bsg_fifo_1r1w_tracked.sv | 53 +++++
 tb/tb_bsg_fifo_1r1w_tracked.sv | 99 +++++++++
 2 files changed

// File: rtl/bsg_fifo_1r1w_tracked.sv
// bsg_fifo_1r1w_tracked: single-clock 1R1W FIFO on a last-op pointer tracker.
// Define BSG_FIFO_1R1W_TRACKED_COUNT_EN to add the count_o occupancy output.
module bsg_fifo_1r1w_tracked #(
   parameter int width_p = 8,
   parameter int els_p = 64,
   localparam int ptr_width_lp = $clog2(els_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
`ifdef BSG_FIFO_1R1W_TRACKED_COUNT_EN
   output logic [$clog2(els_p+1)-1:0] count_o,
`endif
   input  logic               yumi_i
);
   logic [width_p-1:0] r_mem [els_p];
   logic [ptr_width_lp-1:0] r_wptr, r_rptr;
   logic r_last_enq;
   logic w_eq, w_full, w_empty, w_enq, w_deq;
   // equal pointers are disambiguated by whether the last lone op was an enq
   assign w_eq = r_wptr == r_rptr;
   assign w_full = w_eq & r_last_enq;
   assign w_empty = w_eq & ~r_last_enq;
   assign w_enq = v_i & ~w_full;
   assign w_deq = yumi_i & ~w_empty;
   assign ready_o = ~w_full;
   assign v_o = ~w_empty;
   assign data_o = r_mem[r_rptr];
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_last_enq <= 1'b0;
      end else begin
         if (w_enq) r_wptr <= r_wptr + 1'b1;
         if (w_deq) r_rptr <= r_rptr + 1'b1;
         if (w_enq != w_deq) r_last_enq <= w_enq;
      end
   always_ff @(posedge clk_i)
      if (w_enq & ~reset_i) r_mem[r_wptr] <= data_i;
`ifdef BSG_FIFO_1R1W_TRACKED_COUNT_EN
   logic [$clog2(els_p+1)-1:0] r_count;
   assign count_o = r_count;
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) r_count <= '0;
      else if (w_enq & ~w_deq) r_count <= r_count + 1'b1;
      else if (w_deq & ~w_enq) r_count <= r_count - 1'b1;
`endif
endmodule

// File: tb/tb_bsg_fifo_1r1w_tracked.sv
// tb_bsg_fifo_1r1w_tracked: directed plus random checks against a queue model.
module tb_bsg_fifo_1r1w_tracked;
   localparam int W = 8, N = 4;
   logic clk_i = 0, reset_i = 1, v_i = 0, yumi_i = 0;
   logic [W-1:0] data_i = 0, data_o;
   logic ready_o, v_o;
   int checks = 0, errors = 0;
   logic [W-1:0] q[$];
`ifdef BSG_FIFO_1R1W_TRACKED_COUNT_EN
   logic [$clog2(N+1)-1:0] count_o;
`endif
   bsg_fifo_1r1w_tracked #(.width_p(W), .els_p(N)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
      .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
`ifdef BSG_FIFO_1R1W_TRACKED_COUNT_EN
      .count_o(count_o),
`endif
      .yumi_i(yumi_i));
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic chk_state();
      chk("v_o", {31'b0, v_o}, {31'b0, q.size() != 0});
      chk("ready_o", {31'b0, ready_o}, {31'b0, q.size() != N});
      if (q.size() != 0) chk("data_o", {24'b0, data_o}, {24'b0, q[0]});
`ifdef BSG_FIFO_1R1W_TRACKED_COUNT_EN
      chk("count_o", {29'b0, count_o}, q.size());
`endif
   endtask
   task automatic cyc(input logic v, input logic [W-1:0] d, input logic y);
      bit e, dq;
      chk_state();
      v_i = v; data_i = d; yumi_i = y;
      e = v && q.size() < N;
      dq = y && q.size() > 0;
      @(posedge clk_i);
      if (dq) void'(q.pop_front());
      if (e) q.push_back(d);
      @(negedge clk_i);
   endtask
   task automatic mid_reset();
      reset_i = 1;
      #1;
      q.delete();
      chk("rst v_o", {31'b0, v_o}, 32'd0);
      chk("rst ready_o", {31'b0, ready_o}, 32'd1);
      v_i = 1; data_i = 8'hEE; yumi_i = 1;
      @(posedge clk_i);
      @(negedge clk_i);
      v_i = 0; yumi_i = 0;
      chk_state();
      reset_i = 0;
   endtask
   initial begin
      repeat (2) @(negedge clk_i);
      reset_i = 0;
      repeat (3) cyc(0, 0, 0);
      cyc(1, 8'h01, 0);
      #2 mid_reset();
      for (int i = 1; i <= 5; i++) cyc(1, 8'(i * 8'h11), 0);
      chk("full ready_o", {31'b0, ready_o}, 32'd0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1);
      chk("drained v_o", {31'b0, v_o}, 32'd0);
      cyc(1, 8'hA5, 0);
      chk("A5 v_o", {31'b0, v_o}, 32'd1);
      chk("A5 data", {24'b0, data_o}, 32'hA5);
      cyc(0, 0, 1);
      chk("A5 gone", {31'b0, v_o}, 32'd0);
      cyc(1, 8'h00, 0);
      cyc(1, 8'h01, 0);
      for (int i = 2; i < 22; i++) cyc(1, 8'(i), 1);
      chk("steady occ", q.size(), 32'd2);
      cyc(0, 0, 1); cyc(0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'hB0 + i), 0);
      cyc(1, 8'h99, 1);
      chk("deq full ready", {31'b0, ready_o}, 32'd1);
      cyc(1, 8'h99, 0);
      chk("99 last", {24'b0, q[N-1]}, 32'h99);
      repeat (5) cyc(0, 0, 1);
      repeat (2) cyc(0, 0, 1);
      cyc(1, 8'hC1, 0);
      chk("empty yumi", {24'b0, data_o}, 32'hC1);
      cyc(1, 8'hC2, 0); cyc(1, 8'hC3, 0);
      mid_reset();
      cyc(1, 8'h7E, 0);
      chk("7E first", {24'b0, data_o}, 32'h7E);
      cyc(0, 0, 1);
      repeat (400) cyc($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1));
      repeat (5) cyc(0, 0, 1);
      chk_state();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
